// File: rtl/fsm_pp_pkg.sv
// Shared phase encodings, code width and command payload for the command sequencer.
package fsm_pp_pkg;

  localparam int unsigned CODE_W  = 2;
  localparam int unsigned PHASE_W = 3;
  localparam int unsigned COUNT_W = 8;

  typedef enum logic [PHASE_W-1:0] {
    PH_IDLE = 3'd0,
    PH_REG  = 3'd1,
    PH_ADDR = 3'd2,
    PH_DATA = 3'd3,
    PH_WAIT = 3'd4
  } phase_e;

  typedef struct packed {
    logic [CODE_W-1:0] reg_code;
    logic [CODE_W-1:0] addr_code;
    logic [CODE_W-1:0] data_code;
  } cmd_t;

endpackage

// File: rtl/cmd_sequencer_if.sv
// Command handshake, downstream status and phase outputs of the command sequencer.
interface cmd_sequencer_if;

  logic                                cmd_valid;
  logic                                cmd_ready;
  logic [fsm_pp_pkg::CODE_W-1:0]       cmd_reg;
  logic [fsm_pp_pkg::CODE_W-1:0]       cmd_addr;
  logic [fsm_pp_pkg::CODE_W-1:0]       cmd_data;
  logic                                status;
  logic [fsm_pp_pkg::CODE_W-1:0]       register_out;
  logic [fsm_pp_pkg::CODE_W-1:0]       address_out;
  logic [fsm_pp_pkg::CODE_W-1:0]       data_out;
  logic [fsm_pp_pkg::PHASE_W-1:0]      phase;
  logic                                busy;
  logic                                done;
  logic                                error;
  logic [fsm_pp_pkg::COUNT_W-1:0]      done_count;

  modport master (
    output cmd_valid, cmd_reg, cmd_addr, cmd_data, status,
    input  cmd_ready, register_out, address_out, data_out, phase, busy, done, error, done_count
  );

  modport slave (
    input  cmd_valid, cmd_reg, cmd_addr, cmd_data, status,
    output cmd_ready, register_out, address_out, data_out, phase, busy, done, error, done_count
  );

endinterface

// File: rtl/cmd_fifo.sv
// DEPTH-entry command FIFO; full/empty decoded from a registered occupancy counter.
module cmd_fifo
  import fsm_pp_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  cmd_t din,
  output cmd_t dout,
  output logic full,
  output logic empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  cmd_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign dout    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/cmd_sequencer.sv
// Buffers commands and plays each out as REG/ADDR/DATA phases, then waits for status or times out.
module cmd_sequencer
  import fsm_pp_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  cmd_sequencer_if.slave  bus
);

  localparam int unsigned TIMER_W = 8;

  phase_e              state_q;
  logic [TIMER_W-1:0]  timer_q;
  logic [COUNT_W-1:0]  done_count_q;
  logic                live_q;
  logic                done_q;
  logic                error_q;
  logic [CODE_W-1:0]   reg_out_q;
  logic [CODE_W-1:0]   addr_out_q;
  logic [CODE_W-1:0]   data_out_q;
  logic [CODE_W-1:0]   hold_addr_q;
  logic [CODE_W-1:0]   hold_data_q;

  cmd_t fifo_din;
  cmd_t fifo_dout;
  logic fifo_full;
  logic fifo_empty;
  logic ready;
  logic push;
  logic pop;

  // live_q keeps cmd_ready low for the whole reset window.
  assign ready    = live_q && !fifo_full;
  assign push     = bus.cmd_valid && ready;
  assign pop      = (state_q == PH_IDLE) && !fifo_empty;
  assign fifo_din = {bus.cmd_reg, bus.cmd_addr, bus.cmd_data};

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= PH_IDLE;
      timer_q      <= '0;
      done_count_q <= '0;
      live_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      reg_out_q    <= '0;
      addr_out_q   <= '0;
      data_out_q   <= '0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
    end else begin
      live_q     <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      reg_out_q  <= '0;
      addr_out_q <= '0;
      data_out_q <= '0;
      case (state_q)
        PH_IDLE: begin
          if (!fifo_empty) begin
            reg_out_q   <= fifo_dout.reg_code;
            hold_addr_q <= fifo_dout.addr_code;
            hold_data_q <= fifo_dout.data_code;
            state_q     <= PH_REG;
          end
        end
        PH_REG: begin
          addr_out_q <= hold_addr_q;
          state_q    <= PH_ADDR;
        end
        PH_ADDR: begin
          data_out_q <= hold_data_q;
          state_q    <= PH_DATA;
        end
        PH_DATA: begin
          timer_q <= '0;
          state_q <= PH_WAIT;
        end
        PH_WAIT: begin
          // Completion wins over timeout on the last WAIT cycle.
          if (bus.status) begin
            done_q       <= 1'b1;
            done_count_q <= done_count_q + COUNT_W'(1);
            state_q      <= PH_IDLE;
          end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
            error_q <= 1'b1;
            state_q <= PH_IDLE;
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end
        default: state_q <= PH_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready    = ready;
  assign bus.register_out = reg_out_q;
  assign bus.address_out  = addr_out_q;
  assign bus.data_out     = data_out_q;
  assign bus.phase        = state_q;
  assign bus.busy         = (state_q != PH_IDLE) || !fifo_empty;
  assign bus.done         = done_q;
  assign bus.error        = error_q;
  assign bus.done_count   = done_count_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Self-checking bench: cycle-level transaction model plus directed literal checks and random traffic.
module tb_cmd_sequencer;
  import fsm_pp_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;

  cmd_sequencer_if bus();

  cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Model: queue of pending commands; age = cycles since the command left the queue (-1 when idle).
  logic [5:0] mq[$];
  logic [5:0] cur = '0;
  int         age = -1;
  int         wcnt = 0;
  bit         live = 1'b0;
  bit         m_push;
  bit         m_done = 1'b0;
  bit         m_err = 1'b0;
  logic [7:0] m_cnt = '0;

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired (cycle %0d)", nm, cyc);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        mq.delete();
        age = -1; wcnt = 0; live = 1'b0;
        m_cnt = '0; m_done = 1'b0; m_err = 1'b0;
        chk_en = 1'b1;
      end else begin
        m_push = bus.cmd_valid && live && (mq.size() < DEPTH);
        m_done = 1'b0;
        m_err  = 1'b0;
        if (age < 0) begin
          if (mq.size() != 0) begin
            cur = mq.pop_front();
            age = 1;
          end
        end else if (age < 4) begin
          age++;
          if (age == 4) wcnt = 0;
        end else if (bus.status) begin
          m_done = 1'b1; m_cnt = m_cnt + 8'd1; age = -1;
        end else if (wcnt == TIMEOUT - 1) begin
          m_err = 1'b1; age = -1;
        end else begin
          wcnt++;
        end
        if (m_push) mq.push_back({bus.cmd_reg, bus.cmd_addr, bus.cmd_data});
        live = 1'b1;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    logic [2:0] eph;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        eph = (age < 0) ? 3'd0 : ((age >= 4) ? 3'd4 : 3'(age));
        cmp("cmd_ready", 8'(bus.cmd_ready), 8'(live && (mq.size() < DEPTH)));
        cmp("register_out", 8'(bus.register_out), (age == 1) ? 8'(cur[5:4]) : 8'd0);
        cmp("address_out", 8'(bus.address_out), (age == 2) ? 8'(cur[3:2]) : 8'd0);
        cmp("data_out", 8'(bus.data_out), (age == 3) ? 8'(cur[1:0]) : 8'd0);
        cmp("phase", 8'(bus.phase), 8'(eph));
        cmp("busy", 8'(bus.busy), 8'((eph != 3'd0) || (mq.size() != 0)));
        cmp("done", 8'(bus.done), 8'(m_done));
        cmp("error", 8'(bus.error), 8'(m_err));
        cmp("done_count", bus.done_count, m_cnt);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_cmd(input logic [5:0] c);
    bit ok = 1'b0;
    bus.cmd_valid = 1'b1;
    {bus.cmd_reg, bus.cmd_addr, bus.cmd_data} = c;
    for (int i = 0; i < 100 && !ok; i++) begin
      ok = bus.cmd_ready;
      tick();
    end
    bus.cmd_valid = 1'b0;
    if (!ok) bound_fail("push_accept");
  endtask

  task automatic wait_phase(input logic [2:0] ph);
    int n = 0;
    while (bus.phase != ph && n < 200) begin
      tick();
      n++;
    end
    if (bus.phase != ph) bound_fail("wait_phase");
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 500) begin
      tick();
      n++;
    end
    if (bus.busy) bound_fail("wait_idle");
  endtask

  initial begin
    int n;
    bus.cmd_valid = 1'b0;
    bus.cmd_reg = '0; bus.cmd_addr = '0; bus.cmd_data = '0;
    bus.status = 1'b0;

    // Reset state and release.
    repeat (3) tick();
    cmp("rst_ready", 8'(bus.cmd_ready), 8'd0);
    cmp("rst_phase", 8'(bus.phase), 8'd0);
    cmp("rst_count", bus.done_count, 8'd0);
    reset = 1'b0;
    tick();
    cmp("ready_after_reset", 8'(bus.cmd_ready), 8'd1);

    // Single command latency, status on the first WAIT cycle.
    bus.cmd_valid = 1'b1;
    {bus.cmd_reg, bus.cmd_addr, bus.cmd_data} = 6'b11_01_10;
    tick(); bus.cmd_valid = 1'b0;
    cmp("c1_phase", 8'(bus.phase), 8'd0);
    tick(); cmp("c2_register_out", 8'(bus.register_out), 8'd3);
    tick(); cmp("c3_address_out", 8'(bus.address_out), 8'd1);
    tick(); cmp("c4_data_out", 8'(bus.data_out), 8'd2);
    tick(); cmp("c5_phase_wait", 8'(bus.phase), 8'd4);
    bus.status = 1'b1;
    tick();
    cmp("c6_done", 8'(bus.done), 8'd1);
    cmp("c6_count", bus.done_count, 8'd1);
    cmp("c6_phase", 8'(bus.phase), 8'd0);
    bus.status = 1'b0;

    // status held high before WAIT must not complete early.
    bus.status = 1'b1;
    bus.cmd_valid = 1'b1;
    {bus.cmd_reg, bus.cmd_addr, bus.cmd_data} = 6'b01_10_11;
    tick(); bus.cmd_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      cmp("early_done", 8'(bus.done), 8'd0);
      tick();
    end
    cmp("late_done", 8'(bus.done), 8'd1);
    cmp("late_count", bus.done_count, 8'd2);
    bus.status = 1'b0;

    // Timeout exactly 15 cycles after WAIT entry.
    push_cmd(6'b10_10_10);
    wait_phase(3'd4);
    repeat (14) tick();
    cmp("pre_timeout_err", 8'(bus.error), 8'd0);
    tick();
    cmp("timeout_err", 8'(bus.error), 8'd1);
    cmp("timeout_done", 8'(bus.done), 8'd0);
    cmp("timeout_count", bus.done_count, 8'd2);

    // status on the 15th WAIT cycle completes instead of timing out.
    push_cmd(6'b00_11_01);
    wait_phase(3'd4);
    repeat (14) tick();
    bus.status = 1'b1;
    tick();
    cmp("last_cycle_done", 8'(bus.done), 8'd1);
    cmp("last_cycle_err", 8'(bus.error), 8'd0);
    cmp("last_cycle_count", bus.done_count, 8'd3);
    bus.status = 1'b0;

    // Fill the FIFO while stalled in WAIT; fifth push waits for a pop.
    push_cmd(6'b11_11_11);
    wait_phase(3'd4);
    for (int i = 0; i < 4; i++) push_cmd(6'(i * 13 + 5));
    cmp("full_ready", 8'(bus.cmd_ready), 8'd0);
    push_cmd(6'b01_01_01);
    bus.status = 1'b1;
    wait_idle();
    bus.status = 1'b0;

    // Random traffic with occasional completions and timeouts.
    for (int i = 0; i < 400; i++) begin
      bus.cmd_valid = 1'($urandom_range(0, 1));
      bus.cmd_reg  = 2'($urandom_range(0, 3));
      bus.cmd_addr = 2'($urandom_range(0, 3));
      bus.cmd_data = 2'($urandom_range(0, 3));
      bus.status   = ($urandom_range(0, 5) == 0);
      tick();
    end
    bus.cmd_valid = 1'b0;
    bus.status = 1'b1;
    wait_idle();
    bus.status = 1'b0;

    // Reset during ADDR with two commands queued.
    push_cmd(6'b10_01_11);
    push_cmd(6'b01_10_00);
    push_cmd(6'b11_00_10);
    wait_phase(3'd2);
    reset = 1'b1;
    tick();
    cmp("mid_rst_phase", 8'(bus.phase), 8'd0);
    cmp("mid_rst_busy", 8'(bus.busy), 8'd0);
    cmp("mid_rst_done", 8'(bus.done), 8'd0);
    cmp("mid_rst_err", 8'(bus.error), 8'd0);
    cmp("mid_rst_ready", 8'(bus.cmd_ready), 8'd0);
    reset = 1'b0;
    tick();
    cmp("post_rst_ready", 8'(bus.cmd_ready), 8'd1);

    // 256 completions wrap done_count to zero.
    bus.status = 1'b1;
    n = 0;
    for (int i = 0; i < 2000 && n < 256; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_reg  = 2'($urandom_range(0, 3));
      bus.cmd_addr = 2'($urandom_range(0, 3));
      bus.cmd_data = 2'($urandom_range(0, 3));
      tick();
      if (bus.done) n++;
    end
    if (n < 256) bound_fail("wrap_256");
    cmp("wrap_count", bus.done_count, 8'd0);
    bus.cmd_valid = 1'b0;
    wait_idle();
    bus.status = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
